// File: rtl/lc3b_types.sv
// Shared LC-3b types: word/mask aliases plus the memory-arbiter grant and state enums.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  typedef enum logic {
    arb_grant_i = 1'b0,
    arb_grant_d = 1'b1
  } lc3b_arb_grant;

  typedef enum logic [1:0] {
    arb_idle   = 2'd0,
    arb_i_busy = 2'd1,
    arb_d_busy = 2'd2
  } lc3b_arb_state;

endpackage

// File: rtl/mem_arbiter_pick.sv
// Combinational winner selection for the I/D memory arbiter.
// Define ARB_ROUND_ROBIN_EN to alternate ties; otherwise D wins every tie.
module mem_arbiter_pick
  import lc3b_types::*;
(
  input  logic i_req_i,
  input  logic d_req_i,
  input  logic last_grant_i,
  output logic grant_valid_o,
  output logic grant_o
);

`ifndef ARB_ROUND_ROBIN_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant_i;
`endif

  always_comb begin
    grant_valid_o = i_req_i | d_req_i;
    grant_o       = arb_grant_d;
    if (i_req_i && d_req_i) begin
`ifdef ARB_ROUND_ROBIN_EN
      grant_o = (last_grant_i == arb_grant_d) ? arb_grant_i : arb_grant_d;
`else
      grant_o = arb_grant_d;
`endif
    end else if (i_req_i) begin
      grant_o = arb_grant_i;
    end else begin
      grant_o = arb_grant_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between the LC-3b I-fetch and D-access paths; the
// winning request is latched at grant and held until mem_resp (see ARB_ROUND_ROBIN_EN).
module mem_arbiter
  import lc3b_types::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int MASK_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [MASK_W-1:0] d_byte_enable,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [MASK_W-1:0] mem_byte_enable,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  lc3b_arb_state     state_q, state_d;
  lc3b_arb_grant     last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [MASK_W-1:0] mask_q, mask_d;
  logic              read_q, read_d;
  logic              write_q, write_d;
  logic              d_req;
  logic              grant_valid;
  logic              grant_side;

  assign d_req = d_read | d_write;

  mem_arbiter_pick u_pick (
    .i_req_i       (i_read),
    .d_req_i       (d_req),
    .last_grant_i  (last_grant_q),
    .grant_valid_o (grant_valid),
    .grant_o       (grant_side)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    mask_d       = mask_q;
    read_d       = read_q;
    write_d      = write_q;
    case (state_q)
      arb_idle: begin
        if (grant_valid) begin
          last_grant_d = lc3b_arb_grant'(grant_side);
          if (grant_side == arb_grant_d) begin
            // A simultaneous read+write is granted as the write.
            state_d = arb_d_busy;
            addr_d  = d_addr;
            wdata_d = d_wdata;
            mask_d  = d_byte_enable;
            write_d = d_write;
            read_d  = ~d_write;
          end else begin
            state_d = arb_i_busy;
            addr_d  = i_addr;
            mask_d  = {MASK_W{1'b1}};
            read_d  = 1'b1;
            write_d = 1'b0;
          end
        end else begin
          read_d  = 1'b0;
          write_d = 1'b0;
        end
      end
      arb_i_busy, arb_d_busy: begin
        if (mem_resp) begin
          state_d = arb_idle;
          read_d  = 1'b0;
          write_d = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = arb_idle;
        read_d  = 1'b0;
        write_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= arb_idle;
      last_grant_q <= arb_grant_i;
      addr_q       <= {ADDR_W{1'b0}};
      wdata_q      <= {DATA_W{1'b0}};
      mask_q       <= {MASK_W{1'b1}};
      read_q       <= 1'b0;
      write_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      mask_q       <= mask_d;
      read_q       <= read_d;
      write_q      <= write_d;
    end
  end

  assign mem_read        = read_q;
  assign mem_write       = write_q;
  assign mem_addr        = addr_q;
  assign mem_wdata       = wdata_q;
  assign mem_byte_enable = mask_q;

  assign i_resp  = (state_q == arb_i_busy) & mem_resp;
  assign d_resp  = (state_q == arb_d_busy) & mem_resp;
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, tie/reset sequences,
// and randomized traffic against a transaction-level reference model.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        i_read;
  logic [15:0] i_addr;
  logic [15:0] i_rdata;
  logic        i_resp;
  logic        d_read;
  logic        d_write;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic [1:0]  d_byte_enable;
  logic [15:0] d_rdata;
  logic        d_resp;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [1:0]  mem_byte_enable;
  logic [15:0] mem_rdata;
  logic        mem_resp;

  int checks;
  int failures;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MASK_W(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .i_read          (i_read),
    .i_addr          (i_addr),
    .i_rdata         (i_rdata),
    .i_resp          (i_resp),
    .d_read          (d_read),
    .d_write         (d_write),
    .d_addr          (d_addr),
    .d_wdata         (d_wdata),
    .d_byte_enable   (d_byte_enable),
    .d_rdata         (d_rdata),
    .d_resp          (d_resp),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_byte_enable (mem_byte_enable),
    .mem_rdata       (mem_rdata),
    .mem_resp        (mem_resp)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ir, input logic [15:0] ia, input logic dr, input logic dw,
                       input logic [15:0] da, input logic [15:0] dwd, input logic [1:0] dbe,
                       input logic mr, input logic [15:0] mrd);
    i_read = ir; i_addr = ia; d_read = dr; d_write = dw; d_addr = da;
    d_wdata = dwd; d_byte_enable = dbe; mem_resp = mr; mem_rdata = mrd;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic ir; logic [15:0] ia; logic dr; logic dw; logic [15:0] da; logic [15:0] dwd;
    logic [1:0] dbe; logic mr; logic [15:0] mrd;
    logic e_rd; logic e_wr; logic [15:0] e_addr; logic [15:0] e_wd; logic [1:0] e_be;
    logic e_ir; logic e_dr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic ir, input logic [15:0] ia, input logic dr, input logic dw,
                              input logic [15:0] da, input logic [15:0] dwd, input logic [1:0] dbe,
                              input logic mr, input logic [15:0] mrd,
                              input logic e_rd, input logic e_wr, input logic [15:0] e_addr,
                              input logic [15:0] e_wd, input logic [1:0] e_be,
                              input logic e_ir, input logic e_dr);
    vec_t v;
    v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.dwd = dwd; v.dbe = dbe;
    v.mr = mr; v.mrd = mrd; v.e_rd = e_rd; v.e_wr = e_wr; v.e_addr = e_addr;
    v.e_wd = e_wd; v.e_be = e_be; v.e_ir = e_ir; v.e_dr = e_dr;
    return v;
  endfunction

  // ---------------- transaction-level reference model ----------------
  int          m_busy;   // 0 idle, 1 serving I, 2 serving D
  int          m_last;   // 0 = I granted last, 1 = D
  logic [15:0] m_addr;
  logic [15:0] m_wdata;
  logic [1:0]  m_mask;
  logic        m_wr;

  task automatic model_reset();
    m_busy = 0; m_last = 0; m_addr = 16'h0000; m_wdata = 16'h0000; m_mask = 2'b11; m_wr = 1'b0;
  endtask

  task automatic model_check();
    check("rnd_mem_read",  {31'd0, mem_read},  {31'd0, (m_busy == 1) || (m_busy == 2 && !m_wr)});
    check("rnd_mem_write", {31'd0, mem_write}, {31'd0, (m_busy == 2 && m_wr)});
    check("rnd_mem_addr",  {16'd0, mem_addr},  {16'd0, m_addr});
    check("rnd_mem_wdata", {16'd0, mem_wdata}, {16'd0, m_wdata});
    check("rnd_mem_be",    {30'd0, mem_byte_enable}, {30'd0, m_mask});
    check("rnd_i_resp",    {31'd0, i_resp},    {31'd0, (m_busy == 1) && mem_resp});
    check("rnd_d_resp",    {31'd0, d_resp},    {31'd0, (m_busy == 2) && mem_resp});
    check("rnd_i_rdata",   {16'd0, i_rdata},   {16'd0, mem_rdata});
    check("rnd_d_rdata",   {16'd0, d_rdata},   {16'd0, mem_rdata});
  endtask

  task automatic model_step();
    bit win_d;
    if (m_busy != 0) begin
      if (mem_resp) m_busy = 0;
    end else if (i_read || d_read || d_write) begin
      if (i_read && (d_read || d_write)) begin
`ifdef ARB_ROUND_ROBIN_EN
        win_d = (m_last == 0);
`else
        win_d = 1'b1;
`endif
      end else begin
        win_d = !i_read;
      end
      m_last = win_d ? 1 : 0;
      if (win_d) begin
        m_busy = 2; m_addr = d_addr; m_wdata = d_wdata; m_mask = d_byte_enable; m_wr = d_write;
      end else begin
        m_busy = 1; m_addr = i_addr; m_mask = 2'b11; m_wr = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(0, 16'h0, 0, 0, 16'h0, 16'h0, 2'b00, 0, 16'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    bit tie_last_d;
    bit win_d;
    checks = 0;
    failures = 0;
    rst = 1'b0;
    drive(0, 16'h0, 0, 0, 16'h0, 16'h0, 2'b00, 0, 16'h0);

    // Reset state.
    do_reset();
    check("rst_mem_read",  {31'd0, mem_read}, 32'd0);
    check("rst_mem_write", {31'd0, mem_write}, 32'd0);
    check("rst_mem_addr",  {16'd0, mem_addr}, 32'd0);
    check("rst_mem_wdata", {16'd0, mem_wdata}, 32'd0);
    check("rst_mem_be",    {30'd0, mem_byte_enable}, 32'd3);
    check("rst_i_resp",    {31'd0, i_resp}, 32'd0);
    check("rst_d_resp",    {31'd0, d_resp}, 32'd0);

    //                ir  ia      dr dw da      dwd      dbe   mr mrd      rd wr addr     wd       be    ir dr
    vecs.push_back(mk(1, 16'h0040, 0, 0, 16'h0000, 16'h0000, 2'b00, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 2'b11, 0, 0));
    vecs.push_back(mk(1, 16'h0040, 0, 0, 16'h0000, 16'h0000, 2'b00, 0, 16'h0000, 1, 0, 16'h0040, 16'h0000, 2'b11, 0, 0));
    vecs.push_back(mk(1, 16'h0040, 0, 0, 16'h0000, 16'h0000, 2'b00, 0, 16'h0000, 1, 0, 16'h0040, 16'h0000, 2'b11, 0, 0));
    vecs.push_back(mk(1, 16'h0040, 0, 0, 16'h0000, 16'h0000, 2'b00, 0, 16'h0000, 1, 0, 16'h0040, 16'h0000, 2'b11, 0, 0));
    vecs.push_back(mk(1, 16'h0040, 0, 0, 16'h0000, 16'h0000, 2'b00, 1, 16'h1234, 1, 0, 16'h0040, 16'h0000, 2'b11, 1, 0));
    vecs.push_back(mk(0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 2'b00, 0, 16'h0000, 0, 0, 16'h0040, 16'h0000, 2'b11, 0, 0));
    vecs.push_back(mk(0, 16'h0000, 0, 1, 16'h0101, 16'hAB00, 2'b10, 0, 16'h0000, 0, 0, 16'h0040, 16'h0000, 2'b11, 0, 0));
    vecs.push_back(mk(0, 16'h0000, 0, 1, 16'h0101, 16'hAB00, 2'b10, 0, 16'h0000, 0, 1, 16'h0101, 16'hAB00, 2'b10, 0, 0));
    vecs.push_back(mk(0, 16'h0000, 0, 1, 16'h0F0F, 16'hFFFF, 2'b01, 0, 16'h0000, 0, 1, 16'h0101, 16'hAB00, 2'b10, 0, 0));
    vecs.push_back(mk(0, 16'h0000, 0, 1, 16'h0101, 16'hAB00, 2'b10, 1, 16'h5555, 0, 1, 16'h0101, 16'hAB00, 2'b10, 0, 1));
    vecs.push_back(mk(0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 2'b00, 0, 16'h0000, 0, 0, 16'h0101, 16'hAB00, 2'b10, 0, 0));
    vecs.push_back(mk(0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 2'b00, 1, 16'h0BAD, 0, 0, 16'h0101, 16'hAB00, 2'b10, 0, 0));
    vecs.push_back(mk(0, 16'h0000, 1, 1, 16'h0200, 16'h1111, 2'b01, 0, 16'h0000, 0, 0, 16'h0101, 16'hAB00, 2'b10, 0, 0));
    vecs.push_back(mk(0, 16'h0000, 1, 1, 16'h0200, 16'h1111, 2'b01, 1, 16'h2222, 0, 1, 16'h0200, 16'h1111, 2'b01, 0, 1));
    vecs.push_back(mk(0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 2'b00, 0, 16'h0000, 0, 0, 16'h0200, 16'h1111, 2'b01, 0, 0));
    vecs.push_back(mk(0, 16'h0000, 1, 0, 16'h0300, 16'h0000, 2'b01, 0, 16'h0000, 0, 0, 16'h0200, 16'h1111, 2'b01, 0, 0));
    vecs.push_back(mk(0, 16'h0000, 1, 0, 16'h0300, 16'h0000, 2'b01, 1, 16'h7777, 1, 0, 16'h0300, 16'h0000, 2'b01, 0, 1));
    vecs.push_back(mk(0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 2'b00, 0, 16'h0000, 0, 0, 16'h0300, 16'h0000, 2'b01, 0, 0));
    vecs.push_back(mk(1, 16'h0044, 0, 0, 16'h0000, 16'h0000, 2'b00, 0, 16'h0000, 0, 0, 16'h0300, 16'h0000, 2'b01, 0, 0));
    vecs.push_back(mk(1, 16'h0044, 0, 0, 16'h0000, 16'h0000, 2'b00, 1, 16'h4321, 1, 0, 16'h0044, 16'h0000, 2'b11, 1, 0));
    vecs.push_back(mk(0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 2'b00, 0, 16'h0000, 0, 0, 16'h0044, 16'h0000, 2'b11, 0, 0));

    foreach (vecs[k]) begin
      @(negedge clk);
      drive(vecs[k].ir, vecs[k].ia, vecs[k].dr, vecs[k].dw, vecs[k].da, vecs[k].dwd,
            vecs[k].dbe, vecs[k].mr, vecs[k].mrd);
      #1;
      check($sformatf("vec%0d_mem_read", k),  {31'd0, mem_read},  {31'd0, vecs[k].e_rd});
      check($sformatf("vec%0d_mem_write", k), {31'd0, mem_write}, {31'd0, vecs[k].e_wr});
      check($sformatf("vec%0d_mem_addr", k),  {16'd0, mem_addr},  {16'd0, vecs[k].e_addr});
      check($sformatf("vec%0d_mem_wdata", k), {16'd0, mem_wdata}, {16'd0, vecs[k].e_wd});
      check($sformatf("vec%0d_mem_be", k),    {30'd0, mem_byte_enable}, {30'd0, vecs[k].e_be});
      check($sformatf("vec%0d_i_resp", k),    {31'd0, i_resp},    {31'd0, vecs[k].e_ir});
      check($sformatf("vec%0d_d_resp", k),    {31'd0, d_resp},    {31'd0, vecs[k].e_dr});
      check($sformatf("vec%0d_i_rdata", k),   {16'd0, i_rdata},   {16'd0, vecs[k].mrd});
      check($sformatf("vec%0d_d_rdata", k),   {16'd0, d_rdata},   {16'd0, vecs[k].mrd});
    end

    // Tie: both sides hold requests for three back-to-back rounds; last grant was I.
    tie_last_d = 1'b0;
    @(negedge clk);
    drive(1, 16'h0A00, 0, 1, 16'h0D00, 16'hCAFE, 2'b11, 0, 16'h0000);
    #1;
    check("tie_idle_cmd", {30'd0, mem_read, mem_write}, 32'd0);
    for (int r = 0; r < 3; r++) begin
`ifdef ARB_ROUND_ROBIN_EN
      win_d = !tie_last_d;
`else
      win_d = 1'b1;
`endif
      tie_last_d = win_d;
      @(negedge clk);
      #1;
      check($sformatf("tie%0d_mem_write", r), {31'd0, mem_write}, {31'd0, win_d});
      check($sformatf("tie%0d_mem_read", r),  {31'd0, mem_read},  {31'd0, !win_d});
      check($sformatf("tie%0d_mem_addr", r),  {16'd0, mem_addr},  win_d ? 32'h0D00 : 32'h0A00);
      mem_resp = 1'b1;
      mem_rdata = 16'h0F00 + 16'(r);
      #1;
      check($sformatf("tie%0d_i_resp", r), {31'd0, i_resp}, {31'd0, !win_d});
      check($sformatf("tie%0d_d_resp", r), {31'd0, d_resp}, {31'd0, win_d});
      @(negedge clk);
      mem_resp = 1'b0;
      if (r == 2) d_write = 1'b0;
      #1;
      check($sformatf("tie%0d_idle_cmd", r), {30'd0, mem_read, mem_write}, 32'd0);
    end
    // With D gone, the waiting I request is served next.
    @(negedge clk);
    #1;
    check("tie_i_served_read", {31'd0, mem_read}, 32'd1);
    check("tie_i_served_addr", {16'd0, mem_addr}, 32'h0A00);
    mem_resp = 1'b1;
    #1;
    check("tie_i_served_resp", {31'd0, i_resp}, 32'd1);
    @(negedge clk);
    drive(0, 16'h0, 0, 0, 16'h0, 16'h0, 2'b00, 0, 16'h0);

    // Reset while in D_BUSY: abort immediately, no response.
    @(negedge clk);
    drive(0, 16'h0, 0, 1, 16'h0BEE, 16'h1357, 2'b01, 0, 16'h0);
    @(negedge clk);
    #1;
    check("rstbusy_pre_write", {31'd0, mem_write}, 32'd1);
    check("rstbusy_pre_addr",  {16'd0, mem_addr}, 32'h0BEE);
    rst = 1'b1;
    mem_resp = 1'b1;
    #1;
    check("rstbusy_write", {31'd0, mem_write}, 32'd0);
    check("rstbusy_addr",  {16'd0, mem_addr}, 32'd0);
    check("rstbusy_wdata", {16'd0, mem_wdata}, 32'd0);
    check("rstbusy_be",    {30'd0, mem_byte_enable}, 32'd3);
    check("rstbusy_d_resp", {31'd0, d_resp}, 32'd0);
    @(negedge clk);
    drive(0, 16'h0, 0, 0, 16'h0, 16'h0, 2'b00, 1, 16'h0);
    rst = 1'b0;
    #1;
    check("rstbusy_after_write", {31'd0, mem_write}, 32'd0);
    check("rstbusy_after_d_resp", {31'd0, d_resp}, 32'd0);

    // Randomized traffic against the reference model.
    do_reset();
    model_reset();
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      drive(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 2) == 0), 16'($urandom), 16'($urandom),
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 2) == 0), 16'($urandom));
      #1;
      model_check();
      model_step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
